vision_test_ctrl: RTL and testbench
===================================

# vision_test_ctrl

Sequencer for the eye-test flow. Runs the E-chart acuity staircase, then the astigmatism and colour-vision questions, and presents the results. It drives the size, direction, done, state and result inputs of the VGA display top. All display-facing outputs change only on a frame boundary, so the screen never shows a torn or half-updated chart.

## Interface
Parameters:
- MAX_LEVEL, 9: index of the smallest E size; levels run 0 (largest) to MAX_LEVEL.
- TRIALS, 3: E presentations available per level.
- PASS_COUNT, 2: correct answers needed to pass a level (1 ≤ PASS_COUNT ≤ TRIALS).
- TIMEOUT_FRAMES, 300: frames without an answer before a trial is scored wrong.

Ports:
- i_clk  in  1  pixel/system clock; the single clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_frame_start  in  1  one-cycle pulse at the start of each vertical blank.
- i_start  in  1  one-cycle pulse to begin a test.
- i_key_valid  in  1  one-cycle pulse; a direction answer is present.
- i_key_dir  in  2  answered direction (0 up, 1 right, 2 down, 3 left).
- i_yes  in  1  one-cycle pulse, yes answer.
- i_no  in  1  one-cycle pulse, no answer.
- o_size  out  4  displayed E level.
- o_direction  out  2  displayed E direction.
- o_state  out  3  display screen selector.
- o_done  out  1  result screen active.
- o_astigmatism  out  1  1 = astigmatism reported.
- o_color_result  out  1  1 = colour test passed.
- o_acuity  out  4  number of levels passed, 0 to MAX_LEVEL+1.

## Operation
- States and their o_state encodings:
  - IDLE = 0
  - ACUITY = 1
  - ASTIG = 2
  - COLOR = 3
  - RESULT = 4
- IDLE or RESULT, i_start → ACUITY.
  - Clears level, counters, o_acuity, o_astigmatism and o_color_result.
  - Draws a new direction.
- i_start in ACUITY, ASTIG or COLOR is ignored.
- ACUITY, per trial:
  - An answer is accepted only when not pending (see Timing).
  - A match with the internal direction increments `correct`; a mismatch or a timeout increments `wrong`.
  - `correct` reaching PASS_COUNT → level passed. At MAX_LEVEL, o_acuity = MAX_LEVEL+1 and the state goes to ASTIG. Otherwise the level increments and both counters clear.
  - `wrong` exceeding TRIALS−PASS_COUNT → level failed; o_acuity = level and the state goes to ASTIG.
  - Otherwise the next trial starts at the same level.
- Direction generator:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'h5A, stepped every cycle.
  - A new direction takes LFSR[1:0]. If it equals the previous direction, the new direction is LFSR[1:0]+1 mod 4, so consecutive E's always differ.
- ASTIG: i_yes sets o_astigmatism = 1, i_no sets it to 0; then → COLOR.
- COLOR: i_yes sets o_color_result = 1, i_no sets it to 0; then → RESULT.
- RESULT: o_done = 1.
- Ignored inputs:
  - i_yes and i_no asserted in the same cycle.
  - Direction keys outside ACUITY.
  - i_yes/i_no outside ASTIG and COLOR.
- Simultaneous key and timeout in the same cycle: the key is scored and the timeout is discarded.

## Timing
- Reset values:
  - All outputs 0; o_state = IDLE.
  - Internal state IDLE, counters 0, `pending` = 0, LFSR = 8'h5A.
- Every internal change of level, direction or state sets `pending` = 1 one cycle after the triggering input.
- The display registers (o_size, o_direction, o_state, o_done, o_acuity, o_astigmatism, o_color_result) load from the internal values on the first i_frame_start while `pending` = 1. `pending` clears in that same cycle.
- Answers arriving while `pending` = 1 are dropped, so a user cannot answer an E that has not yet been drawn.
- Answer-to-screen latency: 1 cycle + wait for the next frame pulse (at most one frame).
- Timeout counter:
  - Counts i_frame_start pulses only while in ACUITY and not pending.
  - Clears on each display load.
  - Reaching TIMEOUT_FRAMES is scored as wrong.
- An i_start pulse and an i_frame_start pulse in the same cycle are both honoured.
- Reset asserted mid-test returns everything to the reset values immediately (asynchronous).

## Structure
- Package vision_test_pkg contains:
  - vt_state_t enum with the encodings above.
  - Direction constants DIR_UP/RIGHT/DOWN/LEFT.
  - The LFSR seed.
- Sub-module e_dir_gen holds the LFSR and the no-repeat rule.
  - Interface: i_clk, i_rst, i_req, i_prev[1:0], o_dir[1:0].
  - o_dir is valid in the cycle i_req is high.
- The main FSM, counters and display registers live in vision_test_ctrl.

## Test plan
- Reset, then one i_frame_start → all outputs 0, o_state = 0.
- i_start, correct answers at every level (PASS_COUNT = 2) → o_size steps 0..9 on frame boundaries, then o_state = 2 and o_acuity = 10.
- Level 3 answers: correct, wrong, wrong (TRIALS = 3) → o_acuity = 3, o_state = 2 after the next frame.
- No answers for 300 frames at level 0, twice → two timeouts count as wrong, giving o_acuity = 0. A key plus timeout in the same cycle counts as the key.
- Key pulse while pending (before the frame pulse) → counters unchanged. Consecutive o_direction values are never equal over 1000 trials.
- ASTIG i_yes, COLOR i_no → o_astigmatism = 1, o_color_result = 0, o_done = 1, o_state = 4. Then i_start → all results clear. Reset asserted in COLOR → immediate return to the reset values.

Source files
------------

// File: rtl/vision_test_pkg.sv
// Shared types and constants for the eye-test sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package vision_test_pkg;

   // Screen selector values, also driven to the display as o_state.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACUITY = 3'd1,
      ST_ASTIG  = 3'd2,
      ST_COLOR  = 3'd3,
      ST_RESULT = 3'd4
   } vt_state_t;

   // E orientations as shown on screen and as answered on the keypad.
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam logic [7:0] LFSR_SEED = 8'h5A;

endpackage

// File: rtl/e_dir_gen.sv
// Pseudo-random E direction source; the new direction never repeats the previous one.
// Latency: o_dir is combinational from the free-running LFSR, valid while i_req is high.
// Backpressure: none; the LFSR advances every cycle regardless of requests.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-low reset
//   i_req          a new direction is being taken this cycle
//   i_prev[1:0]    direction currently in use
//   o_dir[1:0]     next direction (equals i_prev when i_req is low)
module e_dir_gen
   import vision_test_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_req,
   input  logic [1:0] i_prev,
   output logic [1:0] o_dir
);

   logic [7:0] lfsr;
   logic [1:0] cand;

   // Fibonacci LFSR, taps 8,6,5,4.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   // Bump a repeated direction by one so consecutive E's always differ.
   always_comb begin
      cand = lfsr[1:0];
      if (cand == i_prev) begin
         cand = cand + 2'd1;
      end
      o_dir = i_req ? cand : i_prev;
   end

endmodule

// File: rtl/vision_test_ctrl.sv
// Eye-test sequencer: acuity staircase, astigmatism and colour questions, result screen.
// Latency: internal update 1 cycle after an input; display registers follow on the next frame pulse.
// Backpressure: answers arriving before the pending screen update is drawn are dropped.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-low reset
//   i_frame_start             start-of-vblank pulse; display registers only load here
//   i_start                   begin a test (honoured in IDLE and RESULT)
//   i_key_valid, i_key_dir    direction answer
//   i_yes, i_no               yes/no answer (both at once is ignored)
//   o_size, o_direction       E level and orientation shown
//   o_state, o_done           screen selector, result screen flag
//   o_astigmatism, o_color_result, o_acuity   test results
module vision_test_ctrl
   import vision_test_pkg::*;
#(
   parameter int MAX_LEVEL      = 9,
   parameter int TRIALS         = 3,
   parameter int PASS_COUNT     = 2,
   parameter int TIMEOUT_FRAMES = 300
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_frame_start,
   input  logic       i_start,
   input  logic       i_key_valid,
   input  logic [1:0] i_key_dir,
   input  logic       i_yes,
   input  logic       i_no,
   output logic [3:0] o_size,
   output logic [1:0] o_direction,
   output logic [2:0] o_state,
   output logic       o_done,
   output logic       o_astigmatism,
   output logic       o_color_result,
   output logic [3:0] o_acuity
);

   localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
   localparam int CW = $clog2(TRIALS + 1);

   vt_state_t     state_q, state_d;
   logic [3:0]    level_q, level_d;
   logic [CW-1:0] correct_q, correct_d;
   logic [CW-1:0] wrong_q, wrong_d;
   logic [1:0]    dir_q, dir_d;
   logic [3:0]    acuity_q, acuity_d;
   logic          astig_q, astig_d;
   logic          color_q, color_d;
   logic          pending_q, pending_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic          dir_req;
   logic [1:0]    new_dir;
   logic          load;
   logic          key_ok;
   logic          tmo_hit;
   logic          yn_ok;

   e_dir_gen u_dir_gen (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_req  (dir_req),
      .i_prev (dir_q),
      .o_dir  (new_dir)
   );

   // Display registers copy the internal values on the first frame pulse after any change.
   assign load = i_frame_start & pending_q;

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      correct_d = correct_q;
      wrong_d   = wrong_q;
      dir_d     = dir_q;
      acuity_d  = acuity_q;
      astig_d   = astig_q;
      color_d   = color_q;
      pending_d = pending_q & ~load;
      tmo_d     = tmo_q;
      dir_req   = 1'b0;

      key_ok  = i_key_valid & ~pending_q & (state_q == ST_ACUITY);
      tmo_hit = i_frame_start & ~pending_q & (state_q == ST_ACUITY) &
                (tmo_q == TW'(TIMEOUT_FRAMES - 1));
      yn_ok   = i_yes ^ i_no;

      // Only frames spent looking at a drawn E count toward the timeout.
      if (load) begin
         tmo_d = '0;
      end else if (i_frame_start && !pending_q && state_q == ST_ACUITY) begin
         tmo_d = tmo_q + TW'(1);
      end

      case (state_q)
         ST_IDLE, ST_RESULT: begin
            if (i_start) begin
               state_d   = ST_ACUITY;
               level_d   = '0;
               correct_d = '0;
               wrong_d   = '0;
               acuity_d  = '0;
               astig_d   = 1'b0;
               color_d   = 1'b0;
               tmo_d     = '0;
               dir_req   = 1'b1;
               dir_d     = new_dir;
               // Set wins over the load-clear so a same-cycle frame pulse still shows the new test.
               pending_d = 1'b1;
            end
         end
         ST_ACUITY: begin
            // A key in the timeout cycle is scored instead of the timeout.
            if (key_ok || tmo_hit) begin
               tmo_d     = '0;
               pending_d = 1'b1;
               if (key_ok && i_key_dir == dir_q) begin
                  if (correct_q == CW'(PASS_COUNT - 1)) begin
                     if (level_q == 4'(MAX_LEVEL)) begin
                        acuity_d = 4'(MAX_LEVEL + 1);
                        state_d  = ST_ASTIG;
                     end else begin
                        level_d   = level_q + 4'd1;
                        correct_d = '0;
                        wrong_d   = '0;
                        dir_req   = 1'b1;
                        dir_d     = new_dir;
                     end
                  end else begin
                     correct_d = correct_q + CW'(1);
                     dir_req   = 1'b1;
                     dir_d     = new_dir;
                  end
               end else begin
                  if (wrong_q == CW'(TRIALS - PASS_COUNT)) begin
                     acuity_d = level_q;
                     state_d  = ST_ASTIG;
                  end else begin
                     wrong_d = wrong_q + CW'(1);
                     dir_req = 1'b1;
                     dir_d   = new_dir;
                  end
               end
            end
         end
         ST_ASTIG: begin
            if (yn_ok) begin
               astig_d   = i_yes;
               state_d   = ST_COLOR;
               pending_d = 1'b1;
            end
         end
         ST_COLOR: begin
            if (yn_ok) begin
               color_d   = i_yes;
               state_d   = ST_RESULT;
               pending_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= ST_IDLE;
         level_q   <= '0;
         correct_q <= '0;
         wrong_q   <= '0;
         dir_q     <= DIR_UP;
         acuity_q  <= '0;
         astig_q   <= 1'b0;
         color_q   <= 1'b0;
         pending_q <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         correct_q <= correct_d;
         wrong_q   <= wrong_d;
         dir_q     <= dir_d;
         acuity_q  <= acuity_d;
         astig_q   <= astig_d;
         color_q   <= color_d;
         pending_q <= pending_d;
         tmo_q     <= tmo_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_size         <= '0;
         o_direction    <= '0;
         o_state        <= ST_IDLE;
         o_done         <= 1'b0;
         o_astigmatism  <= 1'b0;
         o_color_result <= 1'b0;
         o_acuity       <= '0;
      end else if (load) begin
         o_size         <= level_q;
         o_direction    <= dir_q;
         o_state        <= state_q;
         o_done         <= (state_q == ST_RESULT);
         o_astigmatism  <= astig_q;
         o_color_result <= color_q;
         o_acuity       <= acuity_q;
      end
   end

endmodule

// File: tb/tb_vision_test_ctrl.sv
// Bench for vision_test_ctrl: table of answer actions with expected screens, plus sequences
// for pending drop, timeouts, key-vs-timeout, direction no-repeat, start+frame, async reset.
// Expected screens go into a queue when an action is driven and are compared at the next frame.
module tb_vision_test_ctrl;

   logic       clk;
   logic       rst_n;
   logic       frame, start, key_vld, yes, no;
   logic [1:0] key_dir;
   logic [3:0] o_size, o_acuity;
   logic [1:0] o_direction;
   logic [2:0] o_state;
   logic       o_done, o_astigmatism, o_color_result;

   vision_test_ctrl dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_frame_start  (frame),
      .i_start        (start),
      .i_key_valid    (key_vld),
      .i_key_dir      (key_dir),
      .i_yes          (yes),
      .i_no           (no),
      .o_size         (o_size),
      .o_direction    (o_direction),
      .o_state        (o_state),
      .o_done         (o_done),
      .o_astigmatism  (o_astigmatism),
      .o_color_result (o_color_result),
      .o_acuity       (o_acuity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {A_START, A_OK, A_BAD, A_YES, A_NO, A_BOTH, A_KIGN} act_e;

   typedef struct {
      act_e       act;
      logic [3:0] size;
      logic [2:0] st;
      logic [3:0] acu;
      logic       ast;
      logic       col;
   } vec_t;

   typedef struct packed {
      logic [3:0] size;
      logic [1:0] dir;
      logic [2:0] st;
      logic       done;
      logic       ast;
      logic       col;
      logic [3:0] acu;
   } disp_t;

   vec_t  tv[$];
   disp_t sb_q[$];
   disp_t exp_d;
   int    checks = 0;
   int    errors = 0;

   // Reference direction source: 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 5A.
   logic [7:0] m_lfsr;
   logic [1:0] m_dir;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 8'h5A;
      else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic void add(input act_e a, input logic [3:0] sz, input logic [2:0] st,
                               input logic [3:0] acu, input logic ast, input logic col);
      vec_t v;
      v.act = a; v.size = sz; v.st = st; v.acu = acu; v.ast = ast; v.col = col;
      tv.push_back(v);
   endfunction

   function automatic void push(input logic [3:0] sz, input logic [2:0] st,
                                input logic [3:0] acu, input logic ast, input logic col);
      disp_t d;
      d.size = sz; d.dir = m_dir; d.st = st; d.done = (st == 3'd4);
      d.ast = ast; d.col = col; d.acu = acu;
      sb_q.push_back(d);
   endfunction

   // One clock of stimulus; dr marks a cycle in which the DUT should draw a new direction.
   task automatic cyc(input logic f, input logic s, input logic kv, input logic [1:0] kd,
                      input logic y, input logic n, input logic dr);
      logic [1:0] c;
      frame = f; start = s; key_vld = kv; key_dir = kd; yes = y; no = n;
      if (dr) begin
         c = m_lfsr[1:0];
         if (c == m_dir) c = c + 2'd1;
         m_dir = c;
      end
      @(posedge clk); #1;
      frame = 0; start = 0; key_vld = 0; key_dir = 2'd0; yes = 0; no = 0;
   endtask

   task automatic chk(input string nm);
      disp_t act;
      if (sb_q.size() > 0) exp_d = sb_q.pop_front();
      act = disp_t'({o_size, o_direction, o_state, o_done, o_astigmatism, o_color_result, o_acuity});
      checks++;
      if (act !== exp_d) begin
         errors++;
         $display("FAIL %s got size=%0d dir=%0d st=%0d done=%0d ast=%0d col=%0d acu=%0d exp size=%0d dir=%0d st=%0d done=%0d ast=%0d col=%0d acu=%0d",
                  nm, act.size, act.dir, act.st, act.done, act.ast, act.col, act.acu,
                  exp_d.size, exp_d.dir, exp_d.st, exp_d.done, exp_d.ast, exp_d.col, exp_d.acu);
      end
   endtask

   task automatic frame_chk(input string nm);
      cyc(1, 0, 0, 2'd0, 0, 0, 0);
      chk(nm);
   endtask

   task automatic do_act(input act_e a, input logic [3:0] sz, input logic [2:0] st,
                         input logic [3:0] acu, input logic ast, input logic col, input string nm);
      logic       dr;
      logic [1:0] pd;
      pd = o_direction;
      dr = (st == 3'd1) && (a == A_START || a == A_OK || a == A_BAD);
      case (a)
         A_START: cyc(0, 1, 0, 2'd0, 0, 0, dr);
         A_OK:    cyc(0, 0, 1, m_dir, 0, 0, dr);
         A_BAD:   cyc(0, 0, 1, m_dir ^ 2'd2, 0, 0, dr);
         A_YES:   cyc(0, 0, 0, 2'd0, 1, 0, 0);
         A_NO:    cyc(0, 0, 0, 2'd0, 0, 1, 0);
         A_BOTH:  cyc(0, 0, 0, 2'd0, 1, 1, 0);
         default: cyc(0, 0, 1, m_dir, 0, 0, 0);
      endcase
      if (a != A_BOTH && a != A_KIGN) push(sz, st, acu, ast, col);
      frame_chk(nm);
      if (dr) begin
         checks++;
         if (o_direction == pd) begin
            errors++;
            $display("FAIL %s_dir_repeat got %0d exp not %0d", nm, o_direction, pd);
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      sb_q.delete();
      exp_d = '0;
      m_dir = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_vals");
      rst_n = 1'b1;
   endtask

   task automatic climb(input string nm);
      for (int l = 0; l <= 9; l++) begin
         do_act(A_OK, 4'(l), 3'd1, 4'd0, 0, 0, nm);
         if (l == 9) do_act(A_OK, 4'd9, 3'd2, 4'd10, 0, 0, nm);
         else        do_act(A_OK, 4'(l + 1), 3'd1, 4'd0, 0, 0, nm);
      end
   endtask

   initial begin
      frame = 0; start = 0; key_vld = 0; key_dir = 2'd0; yes = 0; no = 0;

      // Full ladder, ignored inputs, results, restart, level-3 fail, opposite answers.
      add(A_START, 0, 1, 0, 0, 0);
      for (int l = 0; l <= 9; l++) begin
         add(A_OK, 4'(l), 1, 0, 0, 0);
         if (l == 9) add(A_OK, 9, 2, 10, 0, 0);
         else        add(A_OK, 4'(l + 1), 1, 0, 0, 0);
      end
      add(A_KIGN, 9, 2, 10, 0, 0);
      add(A_BOTH, 9, 2, 10, 0, 0);
      add(A_YES,  9, 3, 10, 1, 0);
      add(A_NO,   9, 4, 10, 1, 0);
      add(A_START, 0, 1, 0, 0, 0);
      for (int l = 0; l < 3; l++) begin
         add(A_OK, 4'(l), 1, 0, 0, 0);
         add(A_OK, 4'(l + 1), 1, 0, 0, 0);
      end
      add(A_OK,  3, 1, 0, 0, 0);
      add(A_BAD, 3, 1, 0, 0, 0);
      add(A_BAD, 3, 2, 3, 0, 0);
      add(A_NO,  3, 3, 3, 0, 0);
      add(A_YES, 3, 4, 3, 0, 1);

      apply_reset();
      frame_chk("reset_frame");

      for (int i = 0; i < tv.size(); i++)
         do_act(tv[i].act, tv[i].size, tv[i].st, tv[i].acu, tv[i].ast, tv[i].col,
                $sformatf("tbl%0d", i));

      // Key while the new screen is still pending is dropped.
      cyc(0, 1, 0, 2'd0, 0, 0, 1);
      cyc(0, 0, 1, m_dir, 0, 0, 0);
      push(0, 1, 0, 0, 0);
      frame_chk("pend_load");
      do_act(A_OK, 0, 1, 0, 0, 0, "pend_ok1");

      // Two timeouts at level 0 fail the level.
      apply_reset();
      do_act(A_START, 0, 1, 0, 0, 0, "tmo_start");
      repeat (299) frame_chk("tmo_wait1");
      cyc(1, 0, 0, 2'd0, 0, 0, 1);
      push(0, 1, 0, 0, 0);
      frame_chk("tmo_first");
      repeat (299) frame_chk("tmo_wait2");
      cyc(1, 0, 0, 2'd0, 0, 0, 0);
      push(0, 2, 0, 0, 0);
      frame_chk("tmo_second");

      // Key in the same cycle as the timeout frame is scored as the key.
      apply_reset();
      do_act(A_START, 0, 1, 0, 0, 0, "kt_start");
      repeat (299) frame_chk("kt_wait1");
      cyc(1, 0, 0, 2'd0, 0, 0, 1);
      push(0, 1, 0, 0, 0);
      frame_chk("kt_tmo");
      repeat (299) frame_chk("kt_wait2");
      cyc(1, 0, 1, m_dir, 0, 0, 1);
      push(0, 1, 0, 0, 0);
      frame_chk("kt_key");
      do_act(A_OK, 1, 1, 0, 0, 0, "kt_pass");

      // Many trials for the no-repeat rule; each run ends with start+frame in one cycle.
      apply_reset();
      do_act(A_START, 0, 1, 0, 0, 0, "nr_start");
      for (int r = 0; r < 50; r++) begin
         climb("nr");
         do_act(A_YES, 9, 3, 10, 1, 0, "nr_yes");
         cyc(0, 0, 0, 2'd0, 0, 1, 0);
         push(9, 4, 10, 1, 0);
         cyc(1, 1, 0, 2'd0, 0, 0, 1);
         chk("sf_load");
         push(0, 1, 0, 0, 0);
         frame_chk("sf_start");
      end

      // Asynchronous reset in COLOR.
      do_act(A_BAD, 0, 1, 0, 0, 0, "rc_bad1");
      do_act(A_BAD, 0, 2, 0, 0, 0, "rc_bad2");
      do_act(A_YES, 0, 3, 0, 1, 0, "rc_color");
      rst_n = 1'b0;
      sb_q.delete();
      exp_d = '0;
      m_dir = 2'd0;
      #1;
      chk("rc_async");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      frame_chk("rc_idle");
      do_act(A_START, 0, 1, 0, 0, 0, "rc_restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
